// File: rtl/chrono_pkg.sv
// ---------------------------------------------------------------------------
// chrono_pkg
//   Shared types and helpers for the MM:SS stopwatch/countdown core.
//   - state_t      : controller state {IDLE, RUN, PAUSE, EXPIRED}
//   - SEG_BLANK    : active-low cathode pattern with every segment and dp off
//   - bcd_to_seg() : BCD digit -> active-high {g,f,e,d,c,b,a}; non-BCD blanks
//   - time_valid() : true when a {ZM,UM,ZS,US} word is a legal MM:SS value
// ---------------------------------------------------------------------------
package chrono_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Standard seven-segment glyphs, bit 0 = segment a.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Every nibble must be a decimal digit and the tens-of-seconds digit <= 5.
  function automatic logic time_valid(input logic [15:0] t);
    return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// ---------------------------------------------------------------------------
// bcd_digit_cnt
//   One decimal digit of the time counter, counting 0..MAX in either
//   direction. Digits are chained through carry (up) and borrow (down).
//   Ports:
//     osc_clk  in   system clock
//     reset    in   synchronous, active-high; digit -> 0
//     ld       in   load ld_val (wins over inc/dec)
//     ld_val   in   4  value to load
//     inc      in   step up; MAX wraps to 0
//     dec      in   step down; 0 wraps to MAX
//     q        out  4  current digit value
//     carry    out  inc while q == MAX (next digit steps up)
//     borrow   out  dec while q == 0   (next digit steps down)
// ---------------------------------------------------------------------------
module bcd_digit_cnt #(
  parameter int unsigned MAX = 9
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  always_ff @(posedge osc_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == MAX_V) ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= (q == 4'd0) ? MAX_V : q - 4'd1;
    end
  end

  assign carry  = inc & (q == MAX_V);
  assign borrow = dec & (q == 4'd0);

endmodule

// File: rtl/chrono_mmss_ctrl.sv
// ---------------------------------------------------------------------------
// chrono_mmss_ctrl
//   MM:SS stopwatch / countdown core driving a 4-digit multiplexed 7-seg
//   display. Single clock domain: the count tick and the digit-scan tick are
//   clock-enable pulses from two prescalers.
//   Parameters:
//     TICK_DIV  osc_clk cycles per count tick (>= 2)
//     SCAN_DIV  osc_clk cycles per displayed digit (>= 2)
//     BLANK_LZ  1: blank the ZM digit while it shows 0
//   Ports:
//     osc_clk     in   system clock
//     reset       in   synchronous, active-high
//     start_stop  in   pulse: toggle run/pause (IDLE->RUN, EXPIRED->IDLE)
//     lap         in   pulse: toggle display freeze while running
//     clear       in   pulse: time := 00:00, state IDLE
//     load        in   pulse: time := preset, state IDLE (ignored in RUN)
//     mode_down   in   level: 1 counts down; sampled in IDLE/PAUSE
//     preset      in   16  BCD {ZM,UM,ZS,US}; illegal values are ignored
//     an          out  4   anode enables, active-low, an[0] = US
//     cat         out  8   {dp,g,f,e,d,c,b,a}, active-low; dp on UM only
//     running     out  high in RUN
//     expired     out  high in EXPIRED
//     time_bcd    out  16  live counter, unaffected by lap freeze
// ---------------------------------------------------------------------------
module chrono_mmss_ctrl
  import chrono_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 200_000,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic        osc_clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic        load,
  input  logic        mode_down,
  input  logic [15:0] preset,
  output logic [3:0]  an,
  output logic [7:0]  cat,
  output logic        running,
  output logic        expired,
  output logic [15:0] time_bcd
);

  localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(TICK_DIV / 2);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q;
  logic [SCAN_W-1:0]   scan_pre_q;
  logic [1:0]          scan_idx_q;
  logic                mode_q;
  logic                freeze_q;
  logic [15:0]         lap_q;
  logic [15:0]         time_q;

  logic                load_acc;
  logic                tick;
  logic                expire_hit;
  logic                dig_ld;
  logic [15:0]         dig_ld_val;
  logic [3:0]          dig_inc, dig_dec, dig_cy, dig_bw;
  logic [1:0]          chain_unused;

  logic [15:0]         disp;
  logic [3:0]          disp_digit;
  logic                blank;

  // -------------------------------------------------------------------------
  // Event qualification. clear beats load; load only counts outside RUN and
  // with a legal preset. The tick is suppressed by clear so that a clear in a
  // tick cycle leaves 00:00 rather than 00:01.
  // -------------------------------------------------------------------------
  assign load_acc = load & ~clear & (state_q != RUN) & time_valid(preset);
  assign tick     = (state_q == RUN) & (pre_q == PRE_LAST) & ~clear;

  // Counting down from 00:01 (or resuming down at 00:00) lands on 00:00 and
  // expires; the digits are forced to zero so the borrow chain never wraps.
  // Expiry also outranks a start_stop in the same cycle.
  assign expire_hit = tick & mode_q & (time_q <= 16'h0001);

  assign dig_ld     = clear | load_acc | expire_hit;
  assign dig_ld_val = load_acc ? preset : 16'h0000;

  assign dig_inc[0] = tick & ~mode_q;
  assign dig_dec[0] = tick &  mode_q & ~expire_hit;
  assign dig_inc[3:1] = dig_cy[2:0];
  assign dig_dec[3:1] = dig_bw[2:0];

  // ZM carry (99:59 rollover, which simply keeps running) and ZM borrow
  // (blocked by the 00:00 guard) have no consumer.
  assign chain_unused = {dig_cy[3], dig_bw[3]};

  bcd_digit_cnt #(.MAX(9)) u_us (
    .osc_clk(osc_clk), .reset(reset), .ld(dig_ld), .ld_val(dig_ld_val[3:0]),
    .inc(dig_inc[0]), .dec(dig_dec[0]), .q(time_q[3:0]),
    .carry(dig_cy[0]), .borrow(dig_bw[0])
  );

  bcd_digit_cnt #(.MAX(5)) u_zs (
    .osc_clk(osc_clk), .reset(reset), .ld(dig_ld), .ld_val(dig_ld_val[7:4]),
    .inc(dig_inc[1]), .dec(dig_dec[1]), .q(time_q[7:4]),
    .carry(dig_cy[1]), .borrow(dig_bw[1])
  );

  bcd_digit_cnt #(.MAX(9)) u_um (
    .osc_clk(osc_clk), .reset(reset), .ld(dig_ld), .ld_val(dig_ld_val[11:8]),
    .inc(dig_inc[2]), .dec(dig_dec[2]), .q(time_q[11:8]),
    .carry(dig_cy[2]), .borrow(dig_bw[2])
  );

  bcd_digit_cnt #(.MAX(9)) u_zm (
    .osc_clk(osc_clk), .reset(reset), .ld(dig_ld), .ld_val(dig_ld_val[15:12]),
    .inc(dig_inc[3]), .dec(dig_dec[3]), .q(time_q[15:12]),
    .carry(dig_cy[3]), .borrow(dig_bw[3])
  );

  assign time_bcd = time_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    if (clear || load_acc) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        // Starting a countdown from 00:00 would expire immediately; ignore it.
        IDLE:    if (start_stop && !(mode_down && (time_q == 16'h0000)))
                   state_d = RUN;
        RUN:     if (expire_hit)      state_d = EXPIRED;
                 else if (start_stop) state_d = PAUSE;
        PAUSE:   if (start_stop)      state_d = RUN;
        EXPIRED: if (start_stop)      state_d = IDLE;
        default:                      state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    running = (state_q == RUN);
    expired = (state_q == EXPIRED);
  end

  // -------------------------------------------------------------------------
  // Count prescaler. Held in PAUSE so a resume continues the partial second;
  // forced to 0 in IDLE so the first tick lands exactly TICK_DIV cycles after
  // start. Keeps running in EXPIRED to time the blink.
  // -------------------------------------------------------------------------
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      pre_q <= '0;
    end else if (clear || load_acc || (state_q == IDLE)) begin
      pre_q <= '0;
    end else if ((state_q == RUN) || (state_q == EXPIRED)) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  // Count direction follows the switch only while stopped.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if ((state_q == IDLE) || (state_q == PAUSE)) begin
      mode_q <= mode_down;
    end
  end

  // -------------------------------------------------------------------------
  // Lap freeze: released in the same cycle the FSM leaves RUN for any reason.
  // -------------------------------------------------------------------------
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      freeze_q <= 1'b0;
      lap_q    <= 16'h0000;
    end else if (state_d != RUN) begin
      freeze_q <= 1'b0;
    end else if ((state_q == RUN) && lap && !start_stop) begin
      freeze_q <= ~freeze_q;
      if (!freeze_q) lap_q <= time_q;
    end
  end

  // -------------------------------------------------------------------------
  // Digit scan: free-running in every state.
  // -------------------------------------------------------------------------
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      scan_pre_q <= '0;
      scan_idx_q <= 2'd0;
    end else if (scan_pre_q == SCAN_LAST) begin
      scan_pre_q <= '0;
      scan_idx_q <= scan_idx_q + 2'd1;
    end else begin
      scan_pre_q <= scan_pre_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Display mux. an and cat are both decoded from registered state, so they
  // switch in the same cycle. In EXPIRED the second half of each prescaler
  // period is dark.
  // -------------------------------------------------------------------------
  always_comb begin
    disp       = freeze_q ? lap_q : time_q;
    disp_digit = disp[{scan_idx_q, 2'b00} +: 4];
    blank      = ((state_q == EXPIRED) && (pre_q >= PRE_HALF)) ||
                 (BLANK_LZ && (scan_idx_q == 2'd3) && (disp[15:12] == 4'd0));
    an         = ~(4'b0001 << scan_idx_q);
    cat        = blank ? SEG_BLANK
                       : {~(scan_idx_q == 2'd2), ~bcd_to_seg(disp_digit)};
  end

endmodule

// File: tb/tb_chrono_mmss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chrono_mmss_ctrl
//   Self-checking bench for chrono_mmss_ctrl with TICK_DIV=4, SCAN_DIV=2.
//   The reference model keeps time as plain seconds and derives the display
//   from a cycle count since reset; outputs are compared on every falling
//   edge. A few hand-computed values pin the model in the directed part.
// ---------------------------------------------------------------------------
module tb_chrono_mmss_ctrl;

  localparam int TD  = 4;
  localparam int SD  = 2;
  localparam bit BLZ = 1'b0;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP   = 3;

  logic        osc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        mode_down = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [3:0]  an;
  logic [7:0]  cat;
  logic        running;
  logic        expired;
  logic [15:0] time_bcd;

  int n_checks = 0;
  int n_err    = 0;

  chrono_mmss_ctrl #(
    .TICK_DIV(TD),
    .SCAN_DIV(SD),
    .BLANK_LZ(BLZ)
  ) dut (
    .osc_clk(osc_clk),
    .reset(reset),
    .start_stop(start_stop),
    .lap(lap),
    .clear(clear),
    .load(load),
    .mode_down(mode_down),
    .preset(preset),
    .an(an),
    .cat(cat),
    .running(running),
    .expired(expired),
    .time_bcd(time_bcd)
  );

  always #5 osc_clk = ~osc_clk;

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit preset_ok(input logic [15:0] p);
    return (p[15:12] < 10) && (p[11:8] < 10) && (p[7:4] < 6) && (p[3:0] < 10);
  endfunction

  function automatic int preset_secs(input logic [15:0] p);
    return int'(p[15:12]) * 600 + int'(p[11:8]) * 60 +
           int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  // -------------------------------------------------------------------------
  // Reference model (seconds-level)
  // -------------------------------------------------------------------------
  int m_secs, m_st, m_mode, m_phase, m_frozen, m_lap, m_cyc;
  bit m_valid = 1'b0;

  always @(posedge osc_clk) begin : model
    int secs, st, mode, phase, frozen, lap_s, old_secs, old_st;
    bit tk;
    if (reset) begin
      m_secs   <= 0;
      m_st     <= S_IDLE;
      m_mode   <= 0;
      m_phase  <= 0;
      m_frozen <= 0;
      m_lap    <= 0;
      m_cyc    <= 0;
      m_valid  <= 1'b1;
    end else begin
      secs = m_secs; st = m_st; mode = m_mode; phase = m_phase;
      frozen = m_frozen; lap_s = m_lap;
      old_secs = secs; old_st = st;
      tk = (st == S_RUN) && (phase == TD - 1);
      if (clear) begin
        secs = 0; st = S_IDLE; phase = 0;
      end else if (load && st != S_RUN && preset_ok(preset)) begin
        secs = preset_secs(preset); st = S_IDLE; phase = 0;
      end else begin
        case (st)
          S_IDLE: begin
            phase = 0;
            if (start_stop && !(mode_down && secs == 0)) st = S_RUN;
          end
          S_RUN: begin
            phase = (phase + 1) % TD;
            if (tk) begin
              if (mode != 0) begin
                if (secs <= 1) begin secs = 0; st = S_EXP; end
                else secs = secs - 1;
              end else begin
                secs = (secs + 1) % 6000;
              end
            end
            if (st == S_RUN) begin
              if (start_stop) st = S_PAUSE;
              else if (lap) begin
                if (frozen == 0) lap_s = old_secs;
                frozen = 1 - frozen;
              end
            end
          end
          S_PAUSE: if (start_stop) st = S_RUN;
          default: begin
            phase = (phase + 1) % TD;
            if (start_stop) st = S_IDLE;
          end
        endcase
      end
      if (st != S_RUN) frozen = 0;
      if (old_st == S_IDLE || old_st == S_PAUSE) mode = mode_down ? 1 : 0;
      m_secs   <= secs;
      m_st     <= st;
      m_mode   <= mode;
      m_phase  <= phase;
      m_frozen <= frozen;
      m_lap    <= lap_s;
      m_cyc    <= m_cyc + 1;
    end
  end

  // -------------------------------------------------------------------------
  // Compare process
  // -------------------------------------------------------------------------
  always @(negedge osc_clk) begin : compare
    logic [15:0] dbcd;
    logic [3:0]  one, e_an, d;
    logic [7:0]  e_cat;
    int          idx;
    bit          blank;
    if (m_valid) begin
      dbcd  = to_bcd(m_frozen != 0 ? m_lap : m_secs);
      idx   = (m_cyc / SD) % 4;
      one   = 4'b0001;
      e_an  = ~(one << idx);
      d     = dbcd[idx*4 +: 4];
      blank = (m_st == S_EXP && m_phase >= TD / 2) ||
              (BLZ && idx == 3 && dbcd[15:12] == 4'd0);
      e_cat = blank ? 8'hFF : {(idx != 2), ~glyph[d]};
      check("an", {28'd0, an}, {28'd0, e_an});
      check("cat", {24'd0, cat}, {24'd0, e_cat});
      check("running", {31'd0, running}, {31'd0, m_st == S_RUN});
      check("expired", {31'd0, expired}, {31'd0, m_st == S_EXP});
      check("time_bcd", {16'd0, time_bcd}, {16'd0, to_bcd(m_secs)});
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic pulse(input bit c, input bit l, input bit s, input bit p);
    clear = c; load = l; start_stop = s; lap = p;
    @(negedge osc_clk);
    clear = 1'b0; load = 1'b0; start_stop = 1'b0; lap = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    check("rst_an", {28'd0, an}, 32'h0000_000E);
    check("rst_cat", {24'd0, cat}, 32'h0000_00C0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_time", {16'd0, time_bcd}, 32'h0000_0000);
    step(4);
    check("scan_um_an", {28'd0, an}, 32'h0000_000B);
    check("scan_um_dp", {24'd0, cat}, 32'h0000_0040);
    step(12);

    // Count up ten ticks, then pause.
    pulse(0, 0, 1, 0);
    step(40);
    check("up_10", {16'd0, time_bcd}, 32'h0000_0010);
    check("up_running", {31'd0, running}, 32'd1);
    pulse(0, 0, 1, 0);
    step(8);
    check("pause_hold", {16'd0, time_bcd}, 32'h0000_0010);
    check("pause_running", {31'd0, running}, 32'd0);

    // Rollover 99:59 -> 00:00 keeps running.
    preset = 16'h9958;
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    step(4);
    check("roll_9959", {16'd0, time_bcd}, 32'h0000_9959);
    step(4);
    check("roll_0000", {16'd0, time_bcd}, 32'h0000_0000);
    check("roll_running", {31'd0, running}, 32'd1);

    // Countdown to expiry.
    pulse(1, 0, 0, 0);
    mode_down = 1'b1;
    preset = 16'h0002;
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    step(4);
    check("down_0001", {16'd0, time_bcd}, 32'h0000_0001);
    step(4);
    check("down_expired", {31'd0, expired}, 32'd1);
    check("down_0000", {16'd0, time_bcd}, 32'h0000_0000);
    pulse(0, 0, 1, 0);
    check("exp_to_idle", {31'd0, expired}, 32'd0);
    pulse(0, 0, 1, 0);
    check("down_zero_noop", {31'd0, running}, 32'd0);

    // Lap freeze.
    mode_down = 1'b0;
    step(1);
    pulse(0, 0, 1, 0);
    step(12);
    check("lap_pre_0003", {16'd0, time_bcd}, 32'h0000_0003);
    pulse(0, 0, 0, 1);
    step(11);
    check("lap_live_0006", {16'd0, time_bcd}, 32'h0000_0006);
    for (int i = 0; i < 8 && an != 4'b1110; i++) step(1);
    check("lap_frozen_us", {24'd0, cat}, 32'h0000_00B0);
    pulse(0, 0, 1, 0);
    step(4);

    // clear together with tick and start_stop; illegal presets.
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    step(3);
    pulse(1, 0, 1, 0);
    check("clr_tick_running", {31'd0, running}, 32'd0);
    check("clr_tick_time", {16'd0, time_bcd}, 32'h0000_0000);
    preset = 16'h0A00;
    pulse(0, 1, 0, 0);
    check("bad_preset_a", {16'd0, time_bcd}, 32'h0000_0000);
    preset = 16'h0060;
    pulse(0, 1, 0, 0);
    check("bad_preset_zs", {16'd0, time_bcd}, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 999) < 2);
      clear      = ($urandom_range(0, 59) == 0);
      load       = ($urandom_range(0, 19) == 0);
      start_stop = ($urandom_range(0, 9) == 0);
      lap        = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mode_down = ~mode_down;
      if (load) begin
        if ($urandom_range(0, 1) == 0) preset = to_bcd($urandom_range(0, 5999));
        else preset = 16'($urandom);
      end
      @(negedge osc_clk);
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0; start_stop = 1'b0; lap = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
